score_display_sched: RTL
========================

Name: score_display_sched

Overview:
- Display scheduler for the Snake 4-digit seven-segment score path.
- Decides which BCD value the shared digit-scan driver shows (live score, final score, high score), computes leading-zero blanking, and owns the high-score register.
- Sits between the game FSM / score counter and the digit-scan driver.

Parameters:
- CLK_HZ, 24000000, clock frequency in Hz; ms prescaler terminal = CLK_HZ/1000-1.
- DWELL_MS, 2000, ms each value is shown while alternating in END.
- BLINK_MS, 250, half-period of new-record blink (optional feature only).

Ports:
- Clk_24mhz input 1: system clock.
- Rst input 1: asynchronous, active-high reset.
- Game_status input 3: one-hot game state; START=001, PLAY=010, END=100.
- Score_bcd input 16: live packed-BCD score, 4 digits, digit0 in [3:0].
- High_clr input 1: single-cycle pulse that clears the high score.
- Disp_bcd output 16: packed BCD sent to the scan driver.
- Disp_blank output 4: per-digit blank mask; 1 = digit off.
- Disp_src output 2: source shown; 00 BANNER, 01 SCORE, 10 FINAL, 11 HIGH.
- High_score output 16: current high score in BCD.
- New_record output 1: last game beat the high score.

Behaviour:
- Reset: all outputs 0, FSM=BANNER, timers 0, Final register 0.
- ms prescaler: counts 0..CLK_HZ/1000-1 and pulses Ms_tick for one cycle at the terminal count. Dwell/blink counters advance only on Ms_tick.
- Status decode: a code that is not one-hot (000, 011, 111, …) holds the current state. Transitions act on a change of Game_status between registered samples.
- FSM states: BANNER, SCORE, FINAL, HIGH.
  - START (any state) -> BANNER; clears New_record.
  - PLAY (any state) -> SCORE.
  - END from SCORE -> FINAL. In the same cycle, Final<=Score_bcd. If Score_bcd > High_score (unsigned 16-bit compare, valid for packed BCD), then High_score<=Score_bcd and New_record<=1.
  - END from BANNER -> HIGH, with no capture and no alternation.
  - FINAL -> HIGH, and HIGH -> FINAL, after DWELL_MS Ms_ticks. This alternation occurs only if FINAL was entered this game.
  - Dwell counter resets to 0 on every state change.
- Disp_bcd by state:
  - BANNER: High_score.
  - SCORE: Score_bcd.
  - FINAL: Final.
  - HIGH: High_score.
  - Registered; one-cycle latency from input to Disp_bcd and Disp_blank.
- Leading-zero blanking: digit k (k=3..1) is blanked if it and every digit above it are 0. Digit0 is never blanked, so 0000 shows "0" with Disp_blank=1110.
- High_clr sets High_score<=0 and New_record<=0. It has priority over a same-cycle capture; Final is still captured.
- Score_bcd is not validated; nibbles >9 are passed and compared as-is (producer guarantees BCD).
- Rst mid-game: immediate return to reset values; the high score is lost.

Optional Feature:
- Macro: SEG_RECORD_BLINK_EN.
- Defined: when New_record=1 in FINAL or HIGH, a blink counter toggles a phase every BLINK_MS Ms_ticks. In the off phase Disp_blank=1111; in the on phase the normal mask applies. The phase resets to on at each state change.
- Undefined: no blink counter; display is steady.

Decomposition:
- Package score_disp_pkg holds:
  - status codes ST_START / ST_PLAY / ST_END;
  - FSM state enum;
  - Disp_src codes;
  - function lz_blank(16-bit bcd) returning the 4-bit mask.
- One sub-module, ms_tick_gen (parameter CLK_HZ; ports Clk_24mhz, Rst, Ms_tick).
- All other logic stays in the top.

Test Plan:
Bench parameters: CLK_HZ=4000 (4 cycles/ms), DWELL_MS=3.
- Reset release, Game_status=001 -> Disp_src=00, Disp_bcd=0000, Disp_blank=1110, New_record=0.
- PLAY, Score_bcd=0x0042 -> one cycle later Disp_src=01, Disp_bcd=0042, Disp_blank=1100.
- PLAY 0x0123 -> END -> High_score=0123, New_record=1, Disp_src=10. After 12 cycles (3 ms) Disp_src=11; after a further 12 cycles Disp_src=10.
- Second game: PLAY 0x0099 -> END, High_score stays 0123 -> New_record=0, shows 0099 (blank 1100) then 0123.
- High_clr in the same cycle as the PLAY->END capture of 0x0500 -> High_score=0000, New_record=0, Final=0500.
- Game_status=011 while in SCORE -> state holds SCORE; with SEG_RECORD_BLINK_EN and a new record, Disp_blank=1111 during alternate BLINK_MS windows in FINAL.

Source files
------------

// File: rtl/score_disp_pkg.sv
// Shared types and helpers for the Snake score display scheduler.
// Status codes, FSM states, display-source codes and leading-zero blanking.
package score_disp_pkg;

  localparam logic [2:0] ST_START = 3'b001;
  localparam logic [2:0] ST_PLAY  = 3'b010;
  localparam logic [2:0] ST_END   = 3'b100;

  localparam logic [1:0] SRC_BANNER = 2'b00;
  localparam logic [1:0] SRC_SCORE  = 2'b01;
  localparam logic [1:0] SRC_FINAL  = 2'b10;
  localparam logic [1:0] SRC_HIGH   = 2'b11;

  // State encodings equal the Disp_src codes so the state register drives Disp_src directly.
  typedef enum logic [1:0] {
    S_BANNER = SRC_BANNER,
    S_SCORE  = SRC_SCORE,
    S_FINAL  = SRC_FINAL,
    S_HIGH   = SRC_HIGH
  } disp_state_e;

  function automatic logic [3:0] lz_blank(input logic [15:0] bcd);
    logic [3:0] m;
    m[3] = (bcd[15:12] == 4'd0);
    m[2] = m[3] && (bcd[11:8] == 4'd0);
    m[1] = m[2] && (bcd[7:4] == 4'd0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle Ms_tick every CLK_HZ/1000 clocks.
module ms_tick_gen #(
  parameter int CLK_HZ = 24000000
) (
  input  logic Clk_24mhz,
  input  logic Rst,
  output logic Ms_tick
);

  localparam int TERM = CLK_HZ / 1000 - 1;
  localparam int CW   = (TERM > 0) ? $clog2(TERM + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk_24mhz or posedge Rst) begin
    if (Rst)                   cnt <= '0;
    else if (cnt == CW'(TERM)) cnt <= '0;
    else                       cnt <= cnt + CW'(1);
  end

  assign Ms_tick = (cnt == CW'(TERM));

endmodule

// File: rtl/score_display_sched.sv
// Chooses what the digit-scan driver shows (live, final, high score) and owns the high score.
// Optional new-record blink is enabled by defining SEG_RECORD_BLINK_EN.
module score_display_sched
  import score_disp_pkg::*;
#(
  parameter int CLK_HZ   = 24000000,
  parameter int DWELL_MS = 2000,
  parameter int BLINK_MS = 250
) (
  input  logic        Clk_24mhz,
  input  logic        Rst,
  input  logic [2:0]  Game_status,
  input  logic [15:0] Score_bcd,
  input  logic        High_clr,
  output logic [15:0] Disp_bcd,
  output logic [3:0]  Disp_blank,
  output logic [1:0]  Disp_src,
  output logic [15:0] High_score,
  output logic        New_record
);

  localparam int DW = $clog2(DWELL_MS + 1);

  logic          ms_tick;
  disp_state_e   state, state_nxt;
  logic [2:0]    status_q;
  logic [DW-1:0] dwell_cnt, dwell_nxt;
  logic [15:0]   final_q, final_nxt, high_nxt, disp_nxt;
  logic          rec_nxt, seen_q, seen_nxt;
  logic          status_ok, status_chg, alternating;
  logic [3:0]    blank_q;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_ms_tick (
    .Clk_24mhz (Clk_24mhz),
    .Rst       (Rst),
    .Ms_tick   (ms_tick)
  );

  assign status_ok   = (Game_status == ST_START) || (Game_status == ST_PLAY) ||
                       (Game_status == ST_END);
  assign status_chg  = (Game_status != status_q);
  // HIGH only alternates back to FINAL when a score was captured this game.
  assign alternating = (state == S_FINAL) || ((state == S_HIGH) && seen_q);

  always_comb begin
    state_nxt = state;
    final_nxt = final_q;
    high_nxt  = High_score;
    rec_nxt   = New_record;
    seen_nxt  = seen_q;
    if (status_chg && status_ok) begin
      case (Game_status)
        ST_START: begin
          state_nxt = S_BANNER;
          rec_nxt   = 1'b0;
          seen_nxt  = 1'b0;
        end
        ST_PLAY: begin
          state_nxt = S_SCORE;
          seen_nxt  = 1'b0;
        end
        default: begin
          if (state == S_SCORE) begin
            state_nxt = S_FINAL;
            final_nxt = Score_bcd;
            seen_nxt  = 1'b1;
            rec_nxt   = (Score_bcd > High_score);
            if (Score_bcd > High_score) high_nxt = Score_bcd;
          end else if (state == S_BANNER) begin
            state_nxt = S_HIGH;
          end
        end
      endcase
    end else if (alternating && ms_tick && (dwell_cnt == DW'(DWELL_MS - 1))) begin
      state_nxt = (state == S_FINAL) ? S_HIGH : S_FINAL;
    end

    if (High_clr) begin
      high_nxt = '0;
      rec_nxt  = 1'b0;
    end

    dwell_nxt = dwell_cnt;
    if (state_nxt != state)         dwell_nxt = '0;
    else if (alternating && ms_tick) dwell_nxt = dwell_cnt + DW'(1);

    case (state_nxt)
      S_SCORE: disp_nxt = Score_bcd;
      S_FINAL: disp_nxt = final_nxt;
      default: disp_nxt = high_nxt;
    endcase
  end

  always_ff @(posedge Clk_24mhz or posedge Rst) begin
    if (Rst) begin
      state      <= S_BANNER;
      status_q   <= '0;
      dwell_cnt  <= '0;
      final_q    <= '0;
      High_score <= '0;
      New_record <= 1'b0;
      seen_q     <= 1'b0;
      Disp_bcd   <= '0;
      blank_q    <= '0;
    end else begin
      state      <= state_nxt;
      status_q   <= Game_status;
      dwell_cnt  <= dwell_nxt;
      final_q    <= final_nxt;
      High_score <= high_nxt;
      New_record <= rec_nxt;
      seen_q     <= seen_nxt;
      Disp_bcd   <= disp_nxt;
      blank_q    <= lz_blank(disp_nxt);
    end
  end

  assign Disp_src = state;

`ifdef SEG_RECORD_BLINK_EN
  localparam int BW = $clog2(BLINK_MS + 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_off;

  always_ff @(posedge Clk_24mhz or posedge Rst) begin
    if (Rst) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (state_nxt != state) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (ms_tick) begin
      if (blink_cnt == BW'(BLINK_MS - 1)) begin
        blink_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  assign Disp_blank = (blink_off && New_record && ((state == S_FINAL) || (state == S_HIGH))) ?
                      4'b1111 : blank_q;
`else
  assign Disp_blank = blank_q;
`endif

endmodule
